// File: rtl/mux_pipe.sv
// mux_pipe: N-channel data selector feeding a 2-entry skid buffer with a
// valid/ready handshake on both sides.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_data    flattened channels, channel k at [k*WIDTH +: WIDTH]
//   sel        channel select, sampled with the beat
//   in_valid   upstream beat present
//   in_ready   a beat can be accepted this cycle (registered state only)
//   flush      discard every buffered beat
//   out_data   selected data of the head entry
//   out_valid  head entry valid
//   out_ready  downstream takes the head this cycle
//   sel_err    head entry was accepted with an out-of-range select
module mux_pipe #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned SEL_W    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      flush,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      sel_err
);

    // Occupancy of the buffer: 0, 1 or 2 entries.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] head_data_q, head_data_d;
    logic             head_err_q, head_err_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_err_q, skid_err_d;

    logic [WIDTH-1:0] sel_data;
    logic             sel_bad;
    logic             accept;
    logic             pop;

    // Out-of-range selects yield zero data and flag the entry.
    always_comb begin
        sel_data = '0;
        sel_bad  = 1'b1;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
                sel_bad  = 1'b0;
            end
        end
    end

    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
    assign out_data  = head_data_q;
    assign sel_err   = head_err_q;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_err_d  = head_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;

        case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d     = StOne;
                    head_data_d = sel_data;
                    head_err_d  = sel_bad;
                end
            end
            StOne: begin
                if (accept && pop) begin
                    head_data_d = sel_data;
                    head_err_d  = sel_bad;
                end else if (accept) begin
                    state_d     = StFull;
                    skid_data_d = sel_data;
                    skid_err_d  = sel_bad;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                // Skid always holds the younger beat; promote it on a pop.
                if (pop) begin
                    state_d     = StOne;
                    head_data_d = skid_data_q;
                    head_err_d  = skid_err_q;
                end
            end
            default: state_d = StEmpty;
        endcase

        // Flush overrides any accept this cycle; data may go stale.
        if (flush) begin
            state_d    = StEmpty;
            head_err_d = 1'b0;
            skid_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StEmpty;
            head_data_q <= '0;
            head_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_err_q  <= head_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
        end
    end

endmodule

// File: tb/tb_mux_pipe.sv
// tb_mux_pipe: directed bench for mux_pipe with 3 channels of 32 bits and a
// 2-bit select. Inputs change 1 time unit after each rising edge and outputs
// are compared at that same point.
module tb_mux_pipe;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned CHANNELS = 3;
    localparam int unsigned SEL_W    = 2;

    localparam logic [31:0] CH0 = 32'h1111_1111;
    localparam logic [31:0] CH1 = 32'h2222_2222;
    localparam logic [31:0] CH2 = 32'h3333_3333;

    logic                      clk;
    logic                      rst;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]          sel;
    logic                      in_valid;
    logic                      in_ready;
    logic                      flush;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      sel_err;

    int n_total;
    int n_bad;

    logic [31:0] exp_ch [3];

    mux_pipe #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        exp_ch[0] = CH0;
        exp_ch[1] = CH1;
        exp_ch[2] = CH2;
        rst       = 1'b1;
        in_data   = {CH2, CH1, CH0};
        sel       = '0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        step();
        step();

        // Reset state
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_data", out_data, 32'h0);
        check("rst_err", 32'(sel_err), 32'd0);
        rst = 1'b0;

        // 1: single beat on the last legal channel
        sel       = 2'd2;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data", out_data, CH2);
        check("t1_err", 32'(sel_err), 32'd0);
        step();
        check("t1_drain", 32'(out_valid), 32'd0);

        // 2: out-of-range select, then a legal one clears the flag
        sel      = 2'd3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_data", out_data, 32'h0);
        check("t2_err", 32'(sel_err), 32'd1);
        step();
        check("t2_drain", 32'(out_valid), 32'd0);
        sel      = 2'd0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("t2_next_data", out_data, CH0);
        check("t2_next_err", 32'(sel_err), 32'd0);
        step();

        // 3: stall fills the skid, third beat refused, drain in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd0;
        step();
        check("t3_ready_one", 32'(in_ready), 32'd1);
        sel = 2'd1;
        step();
        check("t3_full_ready", 32'(in_ready), 32'd0);
        check("t3_full_data", out_data, CH0);
        sel = 2'd2;
        step();
        in_valid = 1'b0;
        check("t3_hold_ready", 32'(in_ready), 32'd0);
        check("t3_hold_valid", 32'(out_valid), 32'd1);
        check("t3_hold_data", out_data, CH0);
        out_ready = 1'b1;
        step();
        check("t3_b_valid", 32'(out_valid), 32'd1);
        check("t3_b_data", out_data, CH1);
        check("t3_b_ready", 32'(in_ready), 32'd1);
        step();
        check("t3_empty", 32'(out_valid), 32'd0);

        // 4: streaming at full rate
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sel = SEL_W'(i % 3);
            step();
            check("t4_valid", 32'(out_valid), 32'd1);
            check("t4_data", out_data, exp_ch[i % 3]);
            check("t4_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("t4_drain", 32'(out_valid), 32'd0);

        // 5: flush a full buffer with in_valid high
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd0;
        step();
        sel = 2'd1;
        step();
        check("t5_full", 32'(in_ready), 32'd0);
        sel   = 2'd2;
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_ready", 32'(in_ready), 32'd1);
        // Flush discards a beat accepted in the same cycle
        in_valid = 1'b1;
        sel      = 2'd0;
        step();
        sel   = 2'd2;
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t5_acc_valid", 32'(out_valid), 32'd0);
        step();
        check("t5_acc_gone", 32'(out_valid), 32'd0);

        // 6: reset while full and in_valid high
        in_valid = 1'b1;
        sel      = 2'd2;
        step();
        sel = 2'd1;
        step();
        check("t6_full", 32'(in_ready), 32'd0);
        rst = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_data", out_data, 32'h0);
        check("t6_err", 32'(sel_err), 32'd0);
        check("t6_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sel       = 2'd1;
        step();
        in_valid = 1'b0;
        check("t6_post_valid", 32'(out_valid), 32'd1);
        check("t6_post_data", out_data, CH1);
        check("t6_post_err", 32'(sel_err), 32'd0);
        step();
        check("t6_post_drain", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
